// File: rtl/stopwatch_lap.sv
// Stopwatch with IDLE/RUNNING/PAUSED control, programmable tick prescaler,
// lap capture, clear command and a wrap pulse on the last minute rollover.
module stopwatch_lap #(
  parameter int CLK_DIV = 1,
  parameter int MIN_W   = 2,
  parameter int MAX_MIN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             lap,
  input  logic             clear,
  output logic [MIN_W-1:0] minute,
  output logic [5:0]       second,
  output logic [MIN_W-1:0] lap_minute,
  output logic [5:0]       lap_second,
  output logic             lap_valid,
  output logic             running,
  output logic             wrap
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MIN);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  state_t           state, state_next;
  logic             start_hist, stop_hist, lap_hist, clear_hist;
  logic             start_press, stop_press, lap_press, clear_press;
  logic [PRE_W-1:0] presc;
  logic             tick, zero, lap_take;

  function automatic logic [5:0] sec_inc(input logic [5:0] s);
    return (s == 6'd59) ? 6'd0 : s + 6'd1;
  endfunction

  function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] m,
                                               input logic [5:0] s);
    if (s != 6'd59)      return m;
    else if (m == MIN_LAST) return '0;
    else                 return m + MIN_W'(1);
  endfunction

  assign start_press = start & ~start_hist;
  assign stop_press  = stop  & ~stop_hist;
  assign lap_press   = lap   & ~lap_hist;
  assign clear_press = clear & ~clear_hist;

  assign tick     = (state == RUNNING) && (presc == PRE_LAST);
  assign zero     = clear_press && (state != RUNNING);
  assign lap_take = lap_press && (state == RUNNING);

  // Stop beats start; clear beats start when not running.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_press && !stop_press && !clear_press) state_next = RUNNING;
      RUNNING: if (stop_press) state_next = PAUSED;
      PAUSED: begin
        if (clear_press)                     state_next = IDLE;
        else if (start_press && !stop_press) state_next = RUNNING;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      start_hist <= 1'b1;
      stop_hist  <= 1'b1;
      lap_hist   <= 1'b1;
      clear_hist <= 1'b1;
      presc      <= '0;
      minute     <= '0;
      second     <= '0;
      lap_minute <= '0;
      lap_second <= '0;
      lap_valid  <= 1'b0;
      running    <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_next;
      running    <= (state_next == RUNNING);
      start_hist <= start;
      stop_hist  <= stop;
      lap_hist   <= lap;
      clear_hist <= clear;
      lap_valid  <= lap_take;
      wrap       <= tick && (minute == MIN_LAST) && (second == 6'd59);
      // Lap captures the pre-tick time so a coincident tick is not included.
      if (lap_take) begin
        lap_minute <= minute;
        lap_second <= second;
      end
      if (zero) begin
        presc      <= '0;
        minute     <= '0;
        second     <= '0;
        lap_minute <= '0;
        lap_second <= '0;
      end else if (state == RUNNING) begin
        if (tick) begin
          presc  <= '0;
          second <= sec_inc(second);
          minute <= min_inc(minute, second);
        end else begin
          presc <= presc + PRE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: directed scenarios with fixed expectations plus
// randomized buttons checked against an elapsed-seconds reference model.
module tb_stopwatch_lap;
  localparam int CLK_DIV = 4;
  localparam int MIN_W   = 2;
  localparam int MAX_MIN = 3;
  localparam int SPAN    = (MAX_MIN + 1) * 60;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [MIN_W-1:0] minute, lap_minute;
  logic [5:0]       second, lap_second;
  logic             lap_valid, running, wrap;

  int errors = 0;
  int checks = 0;

  // Reference model: state 0=idle 1=running 2=paused; time kept as total seconds.
  int m_state, m_t, m_pre, m_lap_t;
  bit m_lapv, m_wrap;
  bit h_st, h_sp, h_lp, h_cl;

  stopwatch_lap #(.CLK_DIV(CLK_DIV), .MIN_W(MIN_W), .MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .lap(lap), .clear(clear),
    .minute(minute), .second(second), .lap_minute(lap_minute), .lap_second(lap_second),
    .lap_valid(lap_valid), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit ps, pp, pl, pc, run;
    if (reset) begin
      m_state = 0; m_t = 0; m_pre = 0; m_lap_t = 0; m_lapv = 0; m_wrap = 0;
      h_st = 1; h_sp = 1; h_lp = 1; h_cl = 1;
      return;
    end
    ps = start && !h_st;
    pp = stop  && !h_sp;
    pl = lap   && !h_lp;
    pc = clear && !h_cl;
    run = (m_state == 1);
    m_lapv = pl && run;
    if (m_lapv) m_lap_t = m_t;
    m_wrap = 0;
    if (run) begin
      if (m_pre == CLK_DIV - 1) begin
        m_pre = 0;
        m_t++;
        if (m_t == SPAN) begin m_t = 0; m_wrap = 1; end
      end else m_pre++;
    end
    if (run) begin
      if (pp) m_state = 2;
    end else if (pc) begin
      m_state = 0; m_t = 0; m_pre = 0; m_lap_t = 0;
    end else if (ps && !pp) m_state = 1;
    h_st = start; h_sp = stop; h_lp = lap; h_cl = clear;
  endtask

  task automatic cyc(input logic st, input logic sp, input logic lp, input logic cl);
    start = st; stop = sp; lap = lp; clear = cl;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if ({minute, second, lap_minute, lap_second, lap_valid, running, wrap} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %0d:%0d lap %0d:%0d lv=%b run=%b wrap=%b want all zero",
               minute, second, lap_minute, lap_second, lap_valid, running, wrap);
    end
    reset = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_start: running=%b want 0", running);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_start_count();
    cyc(1, 0, 0, 0);
    checks++;
    if (running !== 1'b1 || second !== 6'd0) begin
      errors++;
      $display("FAIL start_entry: running=%b second=%0d want 1 0", running, second);
    end
    for (int i = 0; i < 40; i++) cyc(1, 0, 0, 0);
    checks++;
    if (minute !== 2'd0 || second !== 6'd10 || running !== 1'b1) begin
      errors++;
      $display("FAIL start_count: got %0d:%0d run=%b want 0:10 run=1", minute, second, running);
    end
    cyc(0, 0, 0, 0);
    idle_cycles(3);
  endtask

  task automatic test_wrap();
    // Starting 44 edges after entry; 3:59 is reached at edge 956.
    idle_cycles(912);
    checks++;
    if (minute !== 2'd3 || second !== 6'd59 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pre: got %0d:%0d wrap=%b want 3:59 wrap=0", minute, second, wrap);
    end
    idle_cycles(4);
    checks++;
    if (minute !== 2'd0 || second !== 6'd0 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_edge: got %0d:%0d wrap=%b want 0:00 wrap=1", minute, second, wrap);
    end
    idle_cycles(1);
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse: wrap=%b want 0", wrap);
    end
    idle_cycles(3);
    checks++;
    if (minute !== 2'd0 || second !== 6'd1 || running !== 1'b1) begin
      errors++;
      $display("FAIL wrap_continue: got %0d:%0d want 0:01", minute, second);
    end
  endtask

  task automatic test_pause();
    // Edge 964 now; stop pressed on edge 982 leaves the prescaler holding 2.
    idle_cycles(17);
    cyc(0, 1, 0, 0);
    idle_cycles(20);
    checks++;
    if (minute !== 2'd0 || second !== 6'd5 || running !== 1'b0 || m_pre != 2) begin
      errors++;
      $display("FAIL pause_hold: got %0d:%0d run=%b want 0:05 run=0", minute, second, running);
    end
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    checks++;
    if (second !== 6'd5 || running !== 1'b1) begin
      errors++;
      $display("FAIL resume_early: second=%0d run=%b want 5 run=1", second, running);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (minute !== 2'd0 || second !== 6'd6) begin
      errors++;
      $display("FAIL resume_tick: got %0d:%0d want 0:06", minute, second);
    end
  endtask

  task automatic test_lap();
    idle_cycles(244);
    idle_cycles(3);
    cyc(0, 0, 1, 0);
    checks++;
    if (lap_minute !== 2'd1 || lap_second !== 6'd7 || minute !== 2'd1 ||
        second !== 6'd8 || lap_valid !== 1'b1) begin
      errors++;
      $display("FAIL lap_tick: lap %0d:%0d live %0d:%0d lv=%b want lap 1:07 live 1:08 lv=1",
               lap_minute, lap_second, minute, second, lap_valid);
    end
    cyc(0, 0, 1, 0);
    checks++;
    if (lap_valid !== 1'b0) begin
      errors++;
      $display("FAIL lap_pulse: lap_valid=%b want 0", lap_valid);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    checks++;
    if (lap_valid !== 1'b0 || lap_minute !== 2'd1 || lap_second !== 6'd7) begin
      errors++;
      $display("FAIL lap_paused: lv=%b lap %0d:%0d want 0 1:07", lap_valid, lap_minute, lap_second);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    checks++;
    if (running !== 1'b1 || minute !== MIN_W'(m_t / 60) || second !== 6'(m_t % 60) ||
        m_t == 0 || lap_second !== 6'd7) begin
      errors++;
      $display("FAIL clear_running: run=%b got %0d:%0d want %0d:%0d", running, minute, second,
               m_t / 60, m_t % 60);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL startstop_running: running=%b want 0", running);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    idle_cycles(8);
    checks++;
    if (running !== 1'b0 || second !== 6'd0 || minute !== 2'd0) begin
      errors++;
      $display("FAIL startstop_idle: run=%b got %0d:%0d want 0 0:00", running, minute, second);
    end
  endtask

  task automatic test_clear();
    cyc(1, 0, 0, 0);
    idle_cycles(240);
    cyc(0, 0, 1, 0);
    checks++;
    if (lap_minute !== 2'd1 || lap_second !== 6'd0 || lap_valid !== 1'b1) begin
      errors++;
      $display("FAIL lap_1_00: lap %0d:%0d lv=%b want 1:00 1", lap_minute, lap_second, lap_valid);
    end
    idle_cycles(360);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    checks++;
    if (minute !== 2'd2 || second !== 6'd30 || running !== 1'b0) begin
      errors++;
      $display("FAIL pause_2_30: got %0d:%0d run=%b want 2:30 0", minute, second, running);
    end
    cyc(1, 0, 0, 1);
    checks++;
    if ({minute, second, lap_minute, lap_second, lap_valid, running, wrap} !== '0) begin
      errors++;
      $display("FAIL clear_paused: got %0d:%0d lap %0d:%0d run=%b want all zero",
               minute, second, lap_minute, lap_second, running);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset_midcount();
    cyc(1, 0, 0, 0);
    idle_cycles(30);
    reset = 1'b1;
    cyc(1, 0, 0, 0);
    checks++;
    if ({minute, second, running} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %0d:%0d run=%b want 0:00 0", minute, second, running);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
    checks++;
    if (running !== 1'b0 || second !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_held: run=%b second=%0d want 0 0", running, second);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_repress: running=%b want 1", running);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic st, sp, lp, cl;
    st = 0; sp = 0; lp = 0; cl = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 5) == 0)  st = ~st;
      if ($urandom_range(0, 11) == 0) sp = ~sp;
      if ($urandom_range(0, 4) == 0)  lp = ~lp;
      if ($urandom_range(0, 15) == 0) cl = ~cl;
      reset = ($urandom_range(0, 999) == 0);
      cyc(st, sp, lp, cl);
      checks++;
      if (minute !== MIN_W'(m_t / 60) || second !== 6'(m_t % 60) ||
          lap_minute !== MIN_W'(m_lap_t / 60) || lap_second !== 6'(m_lap_t % 60) ||
          lap_valid !== m_lapv || running !== (m_state == 1) || wrap !== m_wrap) begin
        errors++;
        $display("FAIL random[%0d]: got %0d:%0d lap %0d:%0d lv=%b run=%b wrap=%b want %0d:%0d lap %0d:%0d lv=%b run=%b wrap=%b",
                 i, minute, second, lap_minute, lap_second, lap_valid, running, wrap,
                 m_t / 60, m_t % 60, m_lap_t / 60, m_lap_t % 60, m_lapv, m_state == 1, m_wrap);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_wrap();
    test_pause();
    test_lap();
    test_simultaneous();
    test_clear();
    test_reset_midcount();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
Parametrised stopwatch with three states: IDLE, RUNNING and PAUSED.
- Adds a programmable tick prescaler, configurable minute range, a lap-capture register, a clear command and a wrap flag.
- Buttons are level inputs; the block edge-detects them internally.
- Sits between the debounced button inputs and the 7-segment display mux.

Parameters:
CLK_DIV, 1, clk cycles per counted second (>=1).
MIN_W, 2, width of the minute fields.
MAX_MIN, 3, last minute value before wrap (<= 2^MIN_W - 1).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  start/resume button, level
stop  in  1  pause button, level
lap  in  1  lap-capture button, level
clear  in  1  zero-time button, level
minute  out  MIN_W  live minutes
second  out  6  live seconds, 0..59
lap_minute  out  MIN_W  captured minutes
lap_second  out  6  captured seconds
lap_valid  out  1  one-cycle pulse after a capture
running  out  1  high in RUNNING
wrap  out  1  one-cycle pulse on MAX_MIN:59 -> 0:00

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE; minute, second, lap_minute, lap_second = 0.
  - lap_valid, running, wrap = 0; prescaler = 0.
  - Button history registers are loaded with 1, so a button held through reset is not a press.
- Edge detect: a press is registered in the cycle where input=1 and its history register=0. History updates every cycle. One press = one event, however long it is held.
- State transitions, evaluated per edge:
  - IDLE + start press -> RUNNING.
  - RUNNING + stop press -> PAUSED.
  - PAUSED + start press -> RUNNING.
  - PAUSED + clear press -> IDLE: minute, second, prescaler and lap registers = 0.
  - Clear in IDLE: re-zeroes everything (no-op in effect). Clear in RUNNING: ignored. Stop in IDLE/PAUSED: ignored. Start in RUNNING: ignored.
- Simultaneous presses in the same cycle:
  - start+stop: stop wins. RUNNING -> PAUSED; IDLE/PAUSED stays put.
  - start+clear in PAUSED: clear wins, next state IDLE.
- running is registered and equals (state==RUNNING).
- Prescaler:
  - Counts 0..CLK_DIV-1 only in RUNNING; holds its value in PAUSED.
  - The edge where prescaler==CLK_DIV-1 in RUNNING is a tick: prescaler -> 0 and time increments.
  - CLK_DIV=1: every RUNNING cycle is a tick.
  - First increment occurs CLK_DIV edges after the edge that enters RUNNING from IDLE.
- Time increment:
  - second<59: second+1.
  - second==59: second=0 and minute+1.
  - minute==MAX_MIN and second==59: both -> 0 and wrap=1 for exactly that following cycle. Counting continues.
- Lap:
  - A lap press in RUNNING loads lap_minute/lap_second with the minute/second values present before that edge (pre-increment if it coincides with a tick).
  - lap_valid=1 in the next cycle only.
  - Lap in IDLE/PAUSED: ignored, no pulse.
  - Lap is independent of start/stop; lap+stop in the same cycle performs both.
- Outputs are all registered. minute/second never exceed MAX_MIN/59.
- Reset asserted mid-count returns everything to IDLE zero at the next edge, regardless of button levels.

Test Plan:
- CLK_DIV=4, MAX_MIN=3. Reset, start press, hold 40 cycles -> 0:10 at edge 40 after entry; running=1; start held high gives only one event.
- Run to 3:59, then one more tick -> minute=0, second=0, wrap=1 for one cycle; counting continues to 0:01.
- Run to 0:05 with prescaler=2, stop press, wait 20 cycles -> 0:05 held. Start press -> 0:06 exactly 2 edges after resume.
- At 1:07, lap press coincident with a tick -> lap=1:07 (live becomes 1:08), lap_valid one cycle. Lap press in PAUSED -> no lap_valid.
- Start and stop pressed in the same cycle from IDLE -> stays IDLE. From RUNNING -> PAUSED. Clear in RUNNING -> time unchanged.
- PAUSED at 2:30 with lap=1:00, clear press -> IDLE, all outputs 0. Reset asserted with start held high -> IDLE; no start event until start is released and pressed again.
